// File: rtl/evt_ingress_pkg.sv
// Shared types and the CD word packer for the event ingress front-end.
package evt_ingress_pkg;

  localparam logic [3:0] EVT_CD_OFF = 4'h0;
  localparam logic [3:0] EVT_CD_ON  = 4'h1;

  // Widest word the packer can build: 4-bit tag, 16-bit ts, two 16-bit coords.
  localparam int PACK_W = 64;

  typedef enum logic {
    ARB_UART_FIRST  = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_e;

  typedef enum logic {
    SRC_UART   = 1'b0,
    SRC_SENSOR = 1'b1
  } src_e;

  typedef enum logic [2:0] {
    IDX_X_HI = 3'd0,
    IDX_X_LO = 3'd1,
    IDX_Y_HI = 3'd2,
    IDX_Y_LO = 3'd3,
    IDX_POL  = 3'd4
  } byte_idx_e;

  // Fields are masked to their widths, so callers may pass full hi/lo byte pairs.
  function automatic logic [PACK_W-1:0] pack_cd_word(
    input logic        pol,
    input logic [15:0] ts,
    input logic [15:0] x,
    input logic [15:0] y,
    input int          ts_bits,
    input int          coord_bits
  );
    logic [PACK_W-1:0] mask_ts;
    logic [PACK_W-1:0] mask_c;
    logic [PACK_W-1:0] word;
    mask_ts = (64'd1 << ts_bits) - 64'd1;
    mask_c  = (64'd1 << coord_bits) - 64'd1;
    word = {60'd0, (pol ? EVT_CD_ON : EVT_CD_OFF)} << (ts_bits + 2 * coord_bits);
    word = word | (({48'd0, ts} & mask_ts) << (2 * coord_bits));
    word = word | (({48'd0, x} & mask_c) << coord_bits);
    word = word | ({48'd0, y} & mask_c);
    return word;
  endfunction

endpackage

// File: rtl/uart_evt_assembler.sv
// Builds CD event words from 5-byte UART packets, with idle-timeout resync
// and a single-entry pending slot that drops packets when still occupied.
module uart_evt_assembler
  import evt_ingress_pkg::*;
#(
  parameter int COORD_BITS   = 11,
  parameter int TS_BITS      = 6,
  parameter int DATA_WIDTH   = 4 + TS_BITS + 2 * COORD_BITS,
  parameter int BYTE_TIMEOUT = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           ts_now,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  input  logic                  pend_take,
  output logic                  pend_valid,
  output logic [DATA_WIDTH-1:0] pend_data,
  output logic [15:0]           drop_count,
  output logic [7:0]            resync_count
);

  localparam int IDLE_W = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(BYTE_TIMEOUT - 1);

  byte_idx_e             idx;
  byte_idx_e             idx_next;
  logic [7:0]            x_hi;
  logic [7:0]            x_lo;
  logic [7:0]            y_hi;
  logic [7:0]            y_lo;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  timeout;
  logic                  complete;
  logic [DATA_WIDTH-1:0] new_word;

  // A byte arriving on the timeout cycle takes precedence over the resync.
  assign timeout  = (idx != IDX_X_HI) && !byte_valid && (idle_cnt == IDLE_LAST);
  assign complete = byte_valid && (idx == IDX_POL);

  assign new_word = DATA_WIDTH'(pack_cd_word(byte_data[0], ts_now, {x_hi, x_lo},
                                             {y_hi, y_lo}, TS_BITS, COORD_BITS));

  always_ff @(posedge clk) begin
    if (rst) idx <= IDX_X_HI;
    else     idx <= idx_next;
  end

  always_comb begin
    idx_next = idx;
    if (byte_valid) begin
      case (idx)
        IDX_X_HI: idx_next = IDX_X_LO;
        IDX_X_LO: idx_next = IDX_Y_HI;
        IDX_Y_HI: idx_next = IDX_Y_LO;
        IDX_Y_LO: idx_next = IDX_POL;
        default:  idx_next = IDX_X_HI;
      endcase
    end else if (timeout) begin
      idx_next = IDX_X_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_hi <= '0;
      x_lo <= '0;
      y_hi <= '0;
      y_lo <= '0;
    end else if (byte_valid) begin
      case (idx)
        IDX_X_HI: x_hi <= byte_data;
        IDX_X_LO: x_lo <= byte_data;
        IDX_Y_HI: y_hi <= byte_data;
        IDX_Y_LO: y_lo <= byte_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || byte_valid || timeout || (idx == IDX_X_HI)) idle_cnt <= '0;
    else                                                   idle_cnt <= idle_cnt + 1'b1;
  end

  // The slot may be refilled in the same cycle the arbiter drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      drop_count <= '0;
    end else if (complete && (!pend_valid || pend_take)) begin
      pend_valid <= 1'b1;
      pend_data  <= new_word;
    end else begin
      if (pend_take) pend_valid <= 1'b0;
      if (complete && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                     resync_count <= '0;
    else if (timeout && (resync_count != '1))    resync_count <= resync_count + 8'd1;
  end

endmodule

// File: rtl/event_ingress_arbiter.sv
// Merges the sensor word stream and assembled UART events into one registered
// valid/ready stream using fixed-priority or round-robin arbitration.
module event_ingress_arbiter
  import evt_ingress_pkg::*;
#(
  parameter int COORD_BITS   = 11,
  parameter int TS_BITS      = 6,
  parameter int DATA_WIDTH   = 4 + TS_BITS + 2 * COORD_BITS,
  parameter int BYTE_TIMEOUT = 2048,
  parameter int ARB_MODE     = 0,
  parameter int UART_ENABLE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           ts_now,
  input  logic [DATA_WIDTH-1:0] sens_data,
  input  logic                  sens_valid,
  output logic                  sens_ready,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           drop_count,
  output logic [7:0]            resync_count
);

  localparam arb_mode_e MODE = (ARB_MODE != 0) ? ARB_ROUND_ROBIN : ARB_UART_FIRST;
  localparam logic UART_ON = (UART_ENABLE != 0);

  logic                  byte_valid_gated;
  logic                  pend_valid_raw;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_take;
  logic                  load;
  logic                  grant_uart;
  logic                  grant_sensor;
  src_e                  last_grant;

  assign byte_valid_gated = UART_ON && byte_valid;
  assign pend_valid       = UART_ON && pend_valid_raw;

  uart_evt_assembler #(
    .COORD_BITS   (COORD_BITS),
    .TS_BITS      (TS_BITS),
    .DATA_WIDTH   (DATA_WIDTH),
    .BYTE_TIMEOUT (BYTE_TIMEOUT)
  ) u_assembler (
    .clk          (clk),
    .rst          (rst),
    .ts_now       (ts_now),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid_gated),
    .pend_take    (pend_take),
    .pend_valid   (pend_valid_raw),
    .pend_data    (pend_data),
    .drop_count   (drop_count),
    .resync_count (resync_count)
  );

  // Round-robin favours whichever source did not win the previous grant.
  always_comb begin
    grant_uart   = 1'b0;
    grant_sensor = 1'b0;
    if (pend_valid && sens_valid) begin
      if ((MODE == ARB_ROUND_ROBIN) && (last_grant == SRC_UART)) grant_sensor = 1'b1;
      else                                                       grant_uart   = 1'b1;
    end else if (pend_valid) begin
      grant_uart = 1'b1;
    end else if (sens_valid) begin
      grant_sensor = 1'b1;
    end
  end

  assign load       = !out_valid || out_ready;
  assign sens_ready = !rst && load && grant_sensor;
  assign pend_take  = !rst && load && grant_uart;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      last_grant <= SRC_UART;
    end else if (load) begin
      if (grant_uart) begin
        out_valid  <= 1'b1;
        out_data   <= pend_data;
        last_grant <= SRC_UART;
      end else if (grant_sensor) begin
        out_valid  <= 1'b1;
        out_data   <= sens_data;
        last_grant <= SRC_SENSOR;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_ingress_arbiter.sv
// Directed bench: a fixed-priority and a round-robin instance share stimulus.
module tb_event_ingress_arbiter;

  localparam int DW = 32;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   ts_now;
  logic [DW-1:0] sens_data;
  logic          sens_valid;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          out_ready;

  logic          sens_ready0, sens_ready1;
  logic          out_valid0, out_valid1;
  logic [DW-1:0] out_data0, out_data1;
  logic [15:0]   drop0, drop1;
  logic [7:0]    resync0, resync1;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          ordy;
    logic          exp_sr;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  event_ingress_arbiter #(.BYTE_TIMEOUT(TO), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .ts_now(ts_now),
    .sens_data(sens_data), .sens_valid(sens_valid), .sens_ready(sens_ready0),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .drop_count(drop0), .resync_count(resync0)
  );

  event_ingress_arbiter #(.BYTE_TIMEOUT(TO), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .ts_now(ts_now),
    .sens_data(sens_data), .sens_valid(sens_valid), .sens_ready(sens_ready1),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .drop_count(drop1), .resync_count(resync1)
  );

  // ts_now is held at 16'h5A6A for the whole run, whose low 6 bits are 6'h2A.
  function automatic logic [31:0] cd_word(input logic pol, input logic [10:0] x,
                                          input logic [10:0] y);
    return {(pol ? 4'h1 : 4'h0), 6'h2A, x, y};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_both(input string name, input logic [31:0] a0,
                            input logic [31:0] a1, input logic [31:0] exp);
    check_output({name, "/m0"}, a0, exp);
    check_output({name, "/m1"}, a1, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    cycle();
    byte_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b4);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
  endtask

  // Called right after the pol byte's edge, with out_ready high and no sensor traffic.
  task automatic expect_word(input string name, input logic [31:0] exp);
    check_both({name, " valid after pol"}, 32'(out_valid0), 32'(out_valid1), 32'd0);
    cycle();
    check_both({name, " valid"}, 32'(out_valid0), 32'(out_valid1), 32'd1);
    check_both({name, " data"}, out_data0, out_data1, exp);
  endtask

  task automatic apply_stimulus(input int i);
    sens_valid = vecs[i].sv;
    sens_data  = vecs[i].sd;
    out_ready  = vecs[i].ordy;
    #1;
    check_both($sformatf("vec%0d sens_ready", i), 32'(sens_ready0), 32'(sens_ready1),
               32'(vecs[i].exp_sr));
    cycle();
    check_both($sformatf("vec%0d out_valid", i), 32'(out_valid0), 32'(out_valid1),
               32'(vecs[i].exp_ov));
    check_both($sformatf("vec%0d out_data", i), out_data0, out_data1, vecs[i].exp_od);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    ts_now     = 16'h5A6A;
    sens_data  = '0;
    sens_valid = 1'b0;
    byte_data  = '0;
    byte_valid = 1'b0;
    out_ready  = 1'b0;

    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    for (int i = 1; i <= 10; i++)
      vecs[i] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b1, 32'h11111111};
    vecs[12] = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h22222222};
    vecs[13] = '{1'b1, 32'h33333333, 1'b1, 1'b1, 1'b1, 32'h33333333};
    vecs[14] = '{1'b0, 32'h44444444, 1'b1, 1'b0, 1'b0, 32'h33333333};
    vecs[15] = '{1'b0, 32'h44444444, 1'b0, 1'b0, 1'b0, 32'h33333333};

    cycle();
    do_reset();
    check_both("reset out_valid", 32'(out_valid0), 32'(out_valid1), 32'd0);
    check_both("reset out_data", out_data0, out_data1, 32'd0);
    check_both("reset sens_ready", 32'(sens_ready0), 32'(sens_ready1), 32'd0);
    check_both("reset drop_count", 32'(drop0), 32'(drop1), 32'd0);
    check_both("reset resync_count", 32'(resync0), 32'(resync1), 32'd0);

    // Sensor hold under back-pressure, then one word per cycle.
    for (int i = 0; i < 16; i++) apply_stimulus(i);

    // Basic UART packet with out_ready high.
    out_ready = 1'b1;
    send_packet(8'h00, 8'h05, 8'h00, 8'h07, 8'h01);
    expect_word("uart basic", 32'h1A802807);
    cycle();
    check_both("uart single word", 32'(out_valid0), 32'(out_valid1), 32'd0);

    // Conflict: P1 parked in the output, P2 pending, sensor requesting.
    do_reset();
    out_ready = 1'b0;
    send_packet(8'h00, 8'h01, 8'h00, 8'h11, 8'h01);
    send_packet(8'h00, 8'h02, 8'h00, 8'h22, 8'h00);
    check_both("conflict P1 held", out_data0, out_data1, cd_word(1'b1, 11'h001, 11'h011));
    sens_valid = 1'b1;
    sens_data  = 32'hA1A1A1A1;
    out_ready  = 1'b1;
    #1;
    check_output("rr c0 sens_ready/m0", 32'(sens_ready0), 32'd0);
    check_output("rr c0 sens_ready/m1", 32'(sens_ready1), 32'd1);
    cycle();
    check_output("rr c0 data/m0", out_data0, cd_word(1'b0, 11'h002, 11'h022));
    check_output("rr c0 data/m1", out_data1, 32'hA1A1A1A1);
    sens_data = 32'hB2B2B2B2;
    #1;
    check_output("rr c1 sens_ready/m0", 32'(sens_ready0), 32'd1);
    check_output("rr c1 sens_ready/m1", 32'(sens_ready1), 32'd0);
    cycle();
    check_output("rr c1 data/m0", out_data0, 32'hB2B2B2B2);
    check_output("rr c1 data/m1", out_data1, cd_word(1'b0, 11'h002, 11'h022));
    #1;
    check_both("rr c2 sens_ready", 32'(sens_ready0), 32'(sens_ready1), 32'd1);
    cycle();
    check_both("rr c2 data", out_data0, out_data1, 32'hB2B2B2B2);
    sens_valid = 1'b0;
    cycle();
    check_both("rr drained", 32'(out_valid0), 32'(out_valid1), 32'd0);
    check_both("rr no drops", 32'(drop0), 32'(drop1), 32'd0);

    // Drop: output full, first packet pends, second is discarded.
    do_reset();
    out_ready  = 1'b0;
    sens_valid = 1'b1;
    sens_data  = 32'h12345678;
    cycle();
    sens_valid = 1'b0;
    send_packet(8'h00, 8'h01, 8'h00, 8'h02, 8'h01);
    check_both("drop after first", 32'(drop0), 32'(drop1), 32'd0);
    send_packet(8'h00, 8'h03, 8'h00, 8'h04, 8'h00);
    check_both("drop count", 32'(drop0), 32'(drop1), 32'd1);
    check_both("drop out held", out_data0, out_data1, 32'h12345678);
    out_ready = 1'b1;
    cycle();
    check_both("drop pending out", out_data0, out_data1, cd_word(1'b1, 11'h001, 11'h002));
    cycle();
    check_both("drop second lost", 32'(out_valid0), 32'(out_valid1), 32'd0);

    // Timeout: TO-1 idle cycles keep the packet, TO idle cycles resync.
    send_byte(8'hFD);
    send_byte(8'h12);
    send_byte(8'h03);
    repeat (TO - 1) cycle();
    check_both("near timeout resync", 32'(resync0), 32'(resync1), 32'd0);
    send_byte(8'h34);
    send_byte(8'h00);
    expect_word("near timeout word", cd_word(1'b0, 11'h512, 11'h334));
    send_byte(8'hFD);
    send_byte(8'h12);
    send_byte(8'h03);
    repeat (TO) cycle();
    check_both("timeout resync", 32'(resync0), 32'(resync1), 32'd1);
    send_packet(8'hFD, 8'h12, 8'h03, 8'h34, 8'h00);
    expect_word("post resync word", cd_word(1'b0, 11'h512, 11'h334));

    // Reset mid-packet with a full output register.
    out_ready  = 1'b0;
    sens_valid = 1'b1;
    sens_data  = 32'h0F0F0F0F;
    cycle();
    sens_valid = 1'b0;
    send_byte(8'h07);
    send_byte(8'h99);
    check_both("pre-reset out_valid", 32'(out_valid0), 32'(out_valid1), 32'd1);
    rst        = 1'b1;
    out_ready  = 1'b1;
    sens_valid = 1'b1;
    sens_data  = 32'h55555555;
    #1;
    check_both("in-reset sens_ready", 32'(sens_ready0), 32'(sens_ready1), 32'd0);
    cycle();
    rst        = 1'b0;
    sens_valid = 1'b0;
    check_both("mid rst out_valid", 32'(out_valid0), 32'(out_valid1), 32'd0);
    check_both("mid rst out_data", out_data0, out_data1, 32'd0);
    check_both("mid rst drop", 32'(drop0), 32'(drop1), 32'd0);
    check_both("mid rst resync", 32'(resync0), 32'(resync1), 32'd0);
    send_packet(8'h01, 8'h23, 8'h04, 8'h56, 8'h01);
    expect_word("fresh packet", cd_word(1'b1, 11'h123, 11'h456));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
